data_memory_unit: RTL

//  Data-memory responder on the datapath's dm_* port: byte-addressed little-endian RAM of DM_L words.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/dm_lane_align.sv | 48 ++++
 rtl/data_memory_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Memory access size codes shared by the control unit and the data memory,
// plus the clear/ready state type used by the memory's sweep FSM.
package riscv_pkg;

    localparam logic [1:0] MEM_B = 2'b00;
    localparam logic [1:0] MEM_H = 2'b01;
    localparam logic [1:0] MEM_W = 2'b10;

    typedef enum logic {
        DM_CLEAR,
        DM_READY
    } dm_state_t;

    // Half needs an even address, word a 4-byte aligned one; code 11 never maps to an access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            MEM_B:   is_misaligned = 1'b0;
            MEM_H:   is_misaligned = lane[0];
            MEM_W:   is_misaligned = |lane;
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering for the data memory: store byte enables and data shift,
// right-aligned zero-filled load extraction, and misalignment detection.
module dm_lane_align
    import riscv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   size,
    input  logic [1:0]   lane,
    input  logic [W-1:0] store_data,
    input  logic [W-1:0] word,
    output logic [3:0]   be,
    output logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         misalign
);

    logic [W-1:0] shifted;

    always_comb begin
        misalign = is_misaligned(size, lane);
        wdata    = store_data << {lane, 3'b000};
        shifted  = word >> {lane, 3'b000};
        be       = 4'b0000;
        rdata    = '0;
        if (!misalign) begin
            case (size)
                MEM_B: begin
                    be    = 4'b0001 << lane;
                    rdata = {24'h0, shifted[7:0]};
                end
                MEM_H: begin
                    be    = 4'b0011 << lane;
                    rdata = {16'h0, shifted[15:0]};
                end
                MEM_W: begin
                    be    = 4'b1111;
                    rdata = shifted;
                end
                default: begin
                    be    = 4'b0000;
                    rdata = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/data_memory_unit.sv
// Byte-addressed little-endian data RAM with a post-reset clear sweep,
// sticky misalignment fault capture, a saturating store counter and a debug read port.
module data_memory_unit
    import riscv_pkg::*;
#(
    parameter int W    = 32,
    parameter int DM_L = 64,
    parameter int AW   = $clog2(DM_L * (W / 8)),
    parameter int IW   = $clog2(DM_L)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_write,
    input  logic          mem_read,
    input  logic [1:0]    mem_size,
    input  logic [AW-1:0] dm_addr,
    input  logic [W-1:0]  dm_data_in,
    output logic [W-1:0]  dm_data_out,
    output logic          busy,
    output logic          fault,
    output logic [AW-1:0] fault_addr,
    output logic [15:0]   store_cnt,
    input  logic [IW-1:0] dbg_idx,
    output logic [W-1:0]  dbg_data
);

    logic [W-1:0]  mem [DM_L];
    dm_state_t     state;
    logic [IW-1:0] clr_ptr;

    logic [IW-1:0] word_idx;
    logic [1:0]    lane;
    logic [3:0]    be;
    logic [W-1:0]  wdata;
    logic [W-1:0]  rdata;
    logic          misalign;
    logic          ready;
    logic          bad;
    logic          commit;

    assign word_idx = dm_addr[AW-1:2];
    assign lane     = dm_addr[1:0];
    assign ready    = (state == DM_READY);
    assign bad      = ready && (mem_read || mem_write) && misalign;
    assign commit   = ready && mem_write && !misalign;

    dm_lane_align #(.W(W)) u_align (
        .size       (mem_size),
        .lane       (lane),
        .store_data (dm_data_in),
        .word       (mem[word_idx]),
        .be         (be),
        .wdata      (wdata),
        .rdata      (rdata),
        .misalign   (misalign)
    );

    // Loads bypass the clock; a misaligned access already yields zero from the aligner.
    assign dm_data_out = ready ? rdata : '0;
    assign dbg_data    = mem[dbg_idx];

    // The array has no reset of its own: the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == DM_CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (commit) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DM_CLEAR;
            clr_ptr    <= '0;
            busy       <= 1'b1;
            fault      <= 1'b0;
            fault_addr <= '0;
            store_cnt  <= '0;
        end else begin
            case (state)
                DM_CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == IW'(DM_L - 1)) begin
                        state <= DM_READY;
                        busy  <= 1'b0;
                    end
                end
                DM_READY: begin
                    if (bad) begin
                        fault <= 1'b1;
                        if (!fault) fault_addr <= dm_addr;
                    end
                    if (commit && store_cnt != 16'hFFFF) store_cnt <= store_cnt + 16'd1;
                end
                default: begin
                    state <= DM_CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule
